// File: rtl/stroke_triage_pkg.sv
// Shared constants and types for the stroke triage datapath.
package stroke_triage_pkg;

   localparam int unsigned N_SENSORS        = 6;
   localparam int unsigned DEB_CYCLES_DEF   = 16;
   localparam int unsigned STUCK_CYCLES_DEF = 1024;

   typedef enum logic {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } warm_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchroniser, debounce counter, clean output bit and update strobe.
// Optional stuck-active counter is built when STUCK_DETECT_EN is defined.
module debounce_channel
   import stroke_triage_pkg::*;
#(
   parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W        = 5,
   parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic s,
   output logic upd,
   output logic stuck
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             y_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_q, s_d;

   always_comb begin
      cnt_d = '0;
      s_d   = s_q;
      upd   = 1'b0;
      if (y_q != s_q) begin
         if (cnt_q == DEB_LAST) begin
            s_d = y_q;
            upd = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b0;
         y_q     <= 1'b0;
         cnt_q   <= '0;
         s_q     <= 1'b0;
      end else begin
         sync1_q <= raw;
         y_q     <= sync1_q;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
      end
   end

   assign s = s_q;

`ifdef STUCK_DETECT_EN
   localparam logic [15:0] STUCK_MAX = 16'(STUCK_CYCLES);

   logic [15:0] stk_cnt_q, stk_cnt_d;
   logic        stuck_q;

   // Counting starts the edge after s rises; clears on the same edge s falls.
   always_comb begin
      stk_cnt_d = '0;
      if (s_d) begin
         if (s_q && (stk_cnt_q != STUCK_MAX)) begin
            stk_cnt_d = stk_cnt_q + 1'b1;
         end else begin
            stk_cnt_d = stk_cnt_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stk_cnt_q <= '0;
         stuck_q   <= 1'b0;
      end else begin
         stk_cnt_q <= stk_cnt_d;
         stuck_q   <= (stk_cnt_d == STUCK_MAX);
      end
   end

   assign stuck = stuck_q;
`else
   assign stuck = 1'b0;
`endif

endmodule

// File: rtl/stroke_sensor_conditioner.sv
// Synchronises and debounces the six raw sensor lines; flags warm-up completion and changes.
// Optional stuck-active detection is enabled by defining STUCK_DETECT_EN.
module stroke_sensor_conditioner
   import stroke_triage_pkg::*;
#(
   parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W        = 5,
   parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_SENSORS-1:0] RAW,
   output logic [N_SENSORS-1:0] S,
   output logic                 S_VALID,
   output logic                 CHG,
   output logic [N_SENSORS-1:0] STUCK
);

   // Needs to hold DEB_CYCLES+1, and DEB_CYCLES may reach 2^CNT_W.
   localparam int unsigned       WCNT_W    = CNT_W + 2;
   localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(DEB_CYCLES + 1);

   logic [N_SENSORS-1:0] s_bus;
   logic [N_SENSORS-1:0] upd_bus;
   logic [N_SENSORS-1:0] stuck_bus;

   for (genvar i = 0; i < N_SENSORS; i++) begin : g_chan
      debounce_channel #(
         .DEB_CYCLES   (DEB_CYCLES),
         .CNT_W        (CNT_W),
         .STUCK_CYCLES (STUCK_CYCLES)
      ) u_chan (
         .CLK   (CLK),
         .RST   (RST),
         .raw   (RAW[i]),
         .s     (s_bus[i]),
         .upd   (upd_bus[i]),
         .stuck (stuck_bus[i])
      );
   end

   warm_state_e       state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              chg_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         WARMUP: begin
            if (wcnt_q == WARM_LAST) begin
               state_d = RUN;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: state_d = WARMUP;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= WARMUP;
         wcnt_q  <= '0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         chg_q   <= |upd_bus;
      end
   end

   assign S       = s_bus;
   assign S_VALID = (state_q == RUN);
   assign CHG     = chg_q;
   assign STUCK   = stuck_bus;

endmodule

// File: tb/tb_stroke_sensor_conditioner.sv
// Directed self-checking bench for stroke_sensor_conditioner at default parameters.
module tb_stroke_sensor_conditioner;

   localparam int unsigned DEB = 16;

`ifdef STUCK_DETECT_EN
   localparam bit STUCK_ON = 1'b1;
`else
   localparam bit STUCK_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [5:0] raw;
   logic [5:0] s;
   logic       s_valid;
   logic       chg;
   logic [5:0] stuck;

   int n_checks;
   int n_pass;
   int chg_cnt;

   stroke_sensor_conditioner #(
      .DEB_CYCLES   (DEB),
      .CNT_W        (5),
      .STUCK_CYCLES (1024)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .RAW     (raw),
      .S       (s),
      .S_VALID (s_valid),
      .CHG     (chg),
      .STUCK   (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; return 1 time unit after the last one, counting CHG pulses.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (chg) chg_cnt++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      chg_cnt  = 0;
      rst      = 1'b1;
      raw      = 6'b000000;

      // Reset state
      step(3);
      check("rst_s", 32'(s), 32'h0);
      check("rst_chg", 32'(chg), 32'h0);
      check("rst_valid", 32'(s_valid), 32'h0);
      check("rst_stuck", 32'(stuck), 32'h0);

      // Idle warm-up: S_VALID at edge DEB+2 after release
      rst     = 1'b0;
      chg_cnt = 0;
      step(DEB + 1);
      check("warm_valid_early", 32'(s_valid), 32'h0);
      step(1);
      check("warm_valid", 32'(s_valid), 32'h1);
      check("idle_s", 32'(s), 32'h0);
      check("idle_no_chg", 32'(chg_cnt), 32'h0);

      // RAW=000011: S follows at edge DEB+2 with one CHG pulse
      raw     = 6'b000011;
      chg_cnt = 0;
      step(DEB + 1);
      check("lat_s_early", 32'(s), 32'h0);
      step(1);
      check("lat_s", 32'(s), 32'h03);
      check("lat_chg", 32'(chg), 32'h1);
      step(1);
      check("lat_chg_fall", 32'(chg), 32'h0);
      check("lat_chg_cnt", 32'(chg_cnt), 32'h1);

      // 15-cycle glitch on RAW[2] is rejected
      raw     = 6'b000111;
      step(15);
      raw     = 6'b000011;
      chg_cnt = 0;
      step(25);
      check("glitch15_s", 32'(s), 32'h03);
      check("glitch15_chg", 32'(chg_cnt), 32'h0);

      // 16-cycle pulse is accepted, then drops again
      raw     = 6'b000111;
      step(16);
      raw     = 6'b000011;
      step(2);
      check("pulse16_s", 32'(s), 32'h07);
      check("pulse16_chg", 32'(chg), 32'h1);
      step(30);
      check("pulse16_back", 32'(s), 32'h03);

      // RAW[5:4] together: same-edge update, single CHG
      raw     = 6'b110011;
      chg_cnt = 0;
      for (int i = 1; i <= DEB + 3; i++) begin
         step(1);
         if (i == DEB + 1) check("dual_s_early", 32'(s), 32'h03);
         if (i == DEB + 2) check("dual_s", 32'(s), 32'h33);
      end
      check("dual_chg_cnt", 32'(chg_cnt), 32'h1);

      // Reset mid-debounce (cnt=10 after 12 edges)
      raw = 6'b000000;
      step(12);
      rst = 1'b1;
      #1;
      check("midrst_s", 32'(s), 32'h0);
      check("midrst_chg", 32'(chg), 32'h0);
      check("midrst_valid", 32'(s_valid), 32'h0);
      raw = 6'b100001;
      step(2);
      rst = 1'b0;
      step(DEB + 1);
      check("relat_s_early", 32'(s), 32'h0);
      check("relat_valid_early", 32'(s_valid), 32'h0);
      step(1);
      check("relat_s", 32'(s), 32'h21);
      check("relat_valid", 32'(s_valid), 32'h1);

      // Stuck detection on the channels now held at 1
      step(1023);
      check("stuck_early", 32'(stuck), 32'h0);
      step(1);
      check("stuck_set", 32'(stuck), STUCK_ON ? 32'h21 : 32'h0);
      raw = 6'b000000;
      step(DEB + 1);
      check("stuck_hold", 32'(stuck), STUCK_ON ? 32'h21 : 32'h0);
      step(1);
      check("stuck_clr_s", 32'(s), 32'h0);
      check("stuck_clr", 32'(stuck), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
